// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared types and constants for the pipeline controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam int unsigned c_stall_w  = 6;
  localparam int unsigned c_stall_pc = 0;

  localparam logic [5:0] c_stall_none = 6'b000000;
  localparam logic [5:0] c_stall_if   = 6'b000011;
  localparam logic [5:0] c_stall_id   = 6'b000111;
  localparam logic [5:0] c_stall_ex   = 6'b001111;
  localparam logic [5:0] c_stall_mem  = 6'b011111;

  localparam logic [31:0] c_zero_word    = 32'h0000_0000;
  localparam logic [31:0] c_exc_int      = 32'h0000_0001;
  localparam logic [31:0] c_exc_syscall  = 32'h0000_0008;
  localparam logic [31:0] c_exc_break    = 32'h0000_0009;
  localparam logic [31:0] c_exc_ri       = 32'h0000_000a;
  localparam logic [31:0] c_exc_ov       = 32'h0000_000c;
  localparam logic [31:0] c_exc_trap     = 32'h0000_000d;
  localparam logic [31:0] c_exc_eret     = 32'h0000_000e;

  // Only eret returns to EPC; every other nonzero code enters the vector.
  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc,
                                             input logic [31:0] vec);
    logic [31:0] t;
    case (code)
      c_exc_eret:                        t = epc;
      c_exc_int, c_exc_syscall, c_exc_break,
      c_exc_ri, c_exc_ov, c_exc_trap:    t = vec;
      default:                           t = vec;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_stall_merge.sv
// ============================================================================
// pipe_ctrl_stall_merge : priority encoder, deepest stall requester wins
// Revision              : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl_stall_merge
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if,
  input  logic       req_id,
  input  logic       req_ex,
  input  logic       req_mem,
  output logic [5:0] stall
);

  always_comb begin
    stall = c_stall_none;
    if (req_mem)      stall = c_stall_mem;
    else if (req_ex)  stall = c_stall_ex;
    else if (req_id)  stall = c_stall_id;
    else if (req_if)  stall = c_stall_if;
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : stall merge, exception flush/redirect and in-flight fetch drain
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        pc_load,
  output logic [31:0] new_pc,
  output logic        if_discard,
  output logic [31:0] stall_cycles
);

  state_e      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic [5:0]  w_merged;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic        w_pc_load;
  logic [31:0] w_new_pc;
  logic        w_if_discard;
  logic        w_accept;
  logic [31:0] w_target;

  pipe_ctrl_stall_merge u_stall_merge (
    .req_if  (stallreq_if),
    .req_id  (stallreq_id),
    .req_ex  (stallreq_ex),
    .req_mem (stallreq_mem),
    .stall   (w_merged)
  );

  // A data transaction in flight must complete before MEM can be flushed.
  assign w_accept = (excepttype != c_zero_word) && !stallreq_mem;
  assign w_target = exc_target(excepttype, cp0_epc, EXC_VECTOR);

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    w_stall      = w_merged;
    w_flush      = 1'b0;
    w_pc_load    = 1'b0;
    w_new_pc     = tgt_q;
    w_if_discard = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (w_accept) begin
          w_stall = c_stall_none;
          w_flush = 1'b1;
          tgt_d   = w_target;
          if (!stallreq_if) begin
            w_pc_load = 1'b1;
            w_new_pc  = w_target;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Pipeline holds only bubbles here, so other requests are moot.
        w_stall      = c_stall_if;
        w_if_discard = 1'b1;
        if (!stallreq_if) begin
          w_pc_load = 1'b1;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    stall_cycles_d = stall_cycles_q + {31'd0, w_stall[c_stall_pc]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_RUN;
      tgt_q          <= c_zero_word;
      stall_cycles_q <= c_zero_word;
    end else begin
      state_q        <= state_d;
      tgt_q          <= tgt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall        = resetn ? w_stall      : c_stall_none;
  assign flush        = resetn & w_flush;
  assign pc_load      = resetn & w_pc_load;
  assign new_pc       = resetn ? w_new_pc     : c_zero_word;
  assign if_discard   = resetn & w_if_discard;
  assign stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire
